spi_burst_ctrl: RTL and testbench
=================================

// Module: spi_burst_ctrl
// PURPOSE
//  Command sequencer behind the SPI byte shifter. Decodes a command byte, then an
//  address byte, then runs a read or write burst of 1..2^LEN_W bytes. Issues per-byte
//  read/write strobes with an auto-incrementing address toward the register file.
//  Adds burst length, address phase, abort and timeout handling.
// PARAMETERS
//  BYTE_W   8     SPI byte width. The command byte is {opcode[CMD_W], len[LEN_W]} with LEN_W=BYTE_W-CMD_W.
//  CMD_W    4     Opcode field width (MSBs of the command byte).
//  ADDR_W   8     Register address width; must be <= BYTE_W. Address = low ADDR_W bits of the address byte.
//  OP_RD    4'h1  Read opcode.
//  OP_WR    4'h2  Write opcode.
//  TIMEOUT  1024  Maximum cycles to wait for byte_done in any waiting state; >=2.
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous, active-high reset
//  byte_done  in   1       1-cycle pulse: rx_byte valid / byte transfer complete
//  rx_byte    in   BYTE_W  received byte; sampled only when byte_done=1
//  abort      in   1       chip-select release; returns to IDLE at the next edge
//  latch_cmd  out  1       1-cycle pulse when the command byte is captured
//  rd_strobe  out  1       1-cycle pulse: fetch the register at addr for the next TX byte
//  wr_strobe  out  1       1-cycle pulse: write wr_data to addr
//  addr       out  ADDR_W  current burst address
//  wr_data    out  BYTE_W  write data, held stable while wr_strobe=1
//  busy       out  1       1 whenever state != IDLE
//  err        out  1       1-cycle pulse: bad opcode or timeout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and internal counters are 0.
//  All outputs are registered and decoded from nextstate, so each strobe is asserted
//  in the first cycle of its state.
//  States and transitions. abort has priority over every transition below.
//   IDLE: on byte_done, capture op=rx_byte[MSBs] and cnt=rx_byte[LEN_W-1:0]; go to LATCH.
//   LATCH (1 cycle, latch_cmd=1): op==OP_RD or op==OP_WR -> ADDR; otherwise -> IDLE with err=1.
//   ADDR: on byte_done, addr<=rx_byte[ADDR_W-1:0]; RD -> READ, WR -> WRITE_WAIT.
//   READ: rd_strobe=1 on entry to READ and after each byte_done while cnt!=0.
//         On each byte_done: if cnt==0 -> IDLE; else addr++, cnt--.
//   WRITE_WAIT: on byte_done, wr_data<=rx_byte; go to WRITE.
//   WRITE (1 cycle, wr_strobe=1): if cnt==0 -> IDLE; else addr++, cnt--, -> WRITE_WAIT.
//  Burst length = len+1 bytes, so len=0 is a single byte and all-ones is 2^LEN_W bytes.
//  addr increments modulo 2^ADDR_W and wraps silently, e.g. 8'hFF -> 8'h00.
//  Timeout: a counter is cleared on every byte_done and on every state change. It counts
//  in ADDR, READ and WRITE_WAIT. When it reaches TIMEOUT-1 without a byte_done:
//  nextstate=IDLE and err=1.
//  abort=1: nextstate=IDLE. No strobe is issued in that cycle, including when byte_done
//  arrives in the same cycle. err stays 0.
//  byte_done during LATCH or WRITE is ignored, because the SPI shifter cannot produce
//  back-to-back bytes within 2 cycles.
//  rst asserted mid-burst: IDLE at the next edge; any pending strobe is dropped.
// TESTING
//  1 WR single byte: bytes 0x20, 0x10, 0xAB -> latch_cmd once, then exactly one wr_strobe
//    with addr=0x10 and wr_data=0xAB; busy falls on the following cycle.
//  2 RD burst: bytes 0x13, 0x40, then 4 byte_done -> rd_strobe count=4 at addr=0x40..0x43,
//    then IDLE.
//  3 Address wrap: WR, len=1, addr 0xFF, data 0x11, 0x22 -> writes 0xFF=0x11 and 0x00=0x22.
//  4 Bad opcode 0x70 -> latch_cmd then err pulse; no strobes; IDLE 2 cycles after byte_done.
//  5 Timeout: WR cmd and addr, then no byte for TIMEOUT cycles -> err=1, busy=0, no wr_strobe.
//  6 abort during READ, coincident with byte_done -> IDLE next cycle, no rd_strobe, err=0;
//    also assert rst mid-WRITE_WAIT -> all outputs 0.

Source files
------------

// File: rtl/spi_burst_ctrl_if.sv
// Byte-level link between the SPI shifter and the burst sequencer.
// master: SPI shifter side (drives received bytes). slave: sequencer side.
interface spi_burst_ctrl_if #(
   parameter int unsigned BYTE_W = 8,
   parameter int unsigned ADDR_W = 8
) ();

   logic              byte_done;
   logic [BYTE_W-1:0] rx_byte;
   logic              abort;
   logic              latch_cmd;
   logic              rd_strobe;
   logic              wr_strobe;
   logic [ADDR_W-1:0] addr;
   logic [BYTE_W-1:0] wr_data;
   logic              busy;
   logic              err;

   modport master (
      output byte_done, rx_byte, abort,
      input  latch_cmd, rd_strobe, wr_strobe, addr, wr_data, busy, err
   );

   modport slave (
      input  byte_done, rx_byte, abort,
      output latch_cmd, rd_strobe, wr_strobe, addr, wr_data, busy, err
   );

endinterface

// File: rtl/spi_burst_ctrl.sv
// Command sequencer behind the SPI byte shifter: decodes a command byte and an
// address byte, then runs a read or write burst of len+1 bytes with an
// auto-incrementing address. Handles abort (chip-select release) and timeout.
module spi_burst_ctrl #(
   parameter int unsigned BYTE_W  = 8,
   parameter int unsigned CMD_W   = 4,
   parameter int unsigned ADDR_W  = 8,
   parameter logic [CMD_W-1:0] OP_RD = CMD_W'(4'h1),
   parameter logic [CMD_W-1:0] OP_WR = CMD_W'(4'h2),
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic           clk,
   input  logic           rst,
   spi_burst_ctrl_if.slave bus
);

   localparam int unsigned LEN_W = BYTE_W - CMD_W;
   localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_ADDR,
      S_READ,
      S_WRITE_WAIT,
      S_WRITE
   } state_t;

   state_t            state;
   logic [CMD_W-1:0]  op_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [BYTE_W-1:0] wr_data_q;
   logic [TMO_W-1:0]  tmo_q;
   logic              latch_q;
   logic              rd_q;
   logic              wr_q;
   logic              busy_q;
   logic              err_q;

   // State, burst counters and registered outputs; each output is set on the
   // transition into the state it belongs to, so it is valid in that state's first cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         wr_data_q <= '0;
         tmo_q     <= '0;
         latch_q   <= 1'b0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         latch_q <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;

         if (bus.abort) begin
            // chip-select release beats everything, including a same-cycle byte_done
            state  <= S_IDLE;
            busy_q <= 1'b0;
            tmo_q  <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  tmo_q <= '0;
                  if (bus.byte_done) begin
                     op_q    <= bus.rx_byte[BYTE_W-1 -: CMD_W];
                     cnt_q   <= bus.rx_byte[LEN_W-1:0];
                     state   <= S_LATCH;
                     latch_q <= 1'b1;
                     busy_q  <= 1'b1;
                  end
               end

               S_LATCH: begin
                  tmo_q <= '0;
                  if (op_q == OP_RD || op_q == OP_WR) begin
                     state <= S_ADDR;
                  end else begin
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                     err_q  <= 1'b1;
                  end
               end

               S_ADDR: begin
                  if (bus.byte_done) begin
                     tmo_q  <= '0;
                     addr_q <= bus.rx_byte[ADDR_W-1:0];
                     if (op_q == OP_RD) begin
                        state <= S_READ;
                        rd_q  <= 1'b1;
                     end else begin
                        state <= S_WRITE_WAIT;
                     end
                  end else if (tmo_q == TMO_LAST) begin
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                     err_q  <= 1'b1;
                     tmo_q  <= '0;
                  end else begin
                     tmo_q <= tmo_q + TMO_W'(1);
                  end
               end

               S_READ: begin
                  if (bus.byte_done) begin
                     tmo_q <= '0;
                     if (cnt_q == '0) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                     end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                        cnt_q  <= cnt_q - LEN_W'(1);
                        rd_q   <= 1'b1;
                     end
                  end else if (tmo_q == TMO_LAST) begin
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                     err_q  <= 1'b1;
                     tmo_q  <= '0;
                  end else begin
                     tmo_q <= tmo_q + TMO_W'(1);
                  end
               end

               S_WRITE_WAIT: begin
                  if (bus.byte_done) begin
                     tmo_q     <= '0;
                     wr_data_q <= bus.rx_byte;
                     state     <= S_WRITE;
                     wr_q      <= 1'b1;
                  end else if (tmo_q == TMO_LAST) begin
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                     err_q  <= 1'b1;
                     tmo_q  <= '0;
                  end else begin
                     tmo_q <= tmo_q + TMO_W'(1);
                  end
               end

               S_WRITE: begin
                  // byte_done cannot legally arrive here; the shifter needs >2 cycles per byte
                  tmo_q <= '0;
                  if (cnt_q == '0) begin
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     addr_q <= addr_q + ADDR_W'(1);
                     cnt_q  <= cnt_q - LEN_W'(1);
                     state  <= S_WRITE_WAIT;
                  end
               end

               default: begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
                  tmo_q  <= '0;
               end
            endcase
         end
      end
   end

   // Drive the registered outputs onto the link.
   assign bus.latch_cmd = latch_q;
   assign bus.rd_strobe = rd_q;
   assign bus.wr_strobe = wr_q;
   assign bus.addr      = addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed self-checking bench for spi_burst_ctrl.
module tb_spi_burst_ctrl;

   localparam int unsigned T = 64;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   // pulse monitor, sampled 1 time unit after each rising edge
   int         wr_cnt = 0;
   int         rd_cnt = 0;
   int         latch_cnt = 0;
   int         err_cnt = 0;
   logic [7:0] wr_addr_log [16];
   logic [7:0] wr_data_log [16];
   logic [7:0] rd_addr_log [16];

   spi_burst_ctrl_if #(.BYTE_W(8), .ADDR_W(8)) bus ();

   spi_burst_ctrl #(
      .BYTE_W(8), .CMD_W(4), .ADDR_W(8),
      .OP_RD(4'h1), .OP_WR(4'h2), .TIMEOUT(T)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (bus.wr_strobe === 1'b1) begin
         wr_addr_log[wr_cnt % 16] = bus.addr;
         wr_data_log[wr_cnt % 16] = bus.wr_data;
         wr_cnt++;
      end
      if (bus.rd_strobe === 1'b1) begin
         rd_addr_log[rd_cnt % 16] = bus.addr;
         rd_cnt++;
      end
      if (bus.latch_cmd === 1'b1) latch_cnt++;
      if (bus.err === 1'b1) err_cnt++;
   end

   // one byte_done pulse; returns at the falling edge after the capturing edge
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.byte_done = 1'b1;
      bus.rx_byte   = b;
      @(negedge clk);
      bus.byte_done = 1'b0;
      bus.rx_byte   = 8'h00;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      tests++; if (bus.addr !== 8'h00) begin fails++; $display("FAIL reset_addr got %h want 00", bus.addr); end
      tests++; if (bus.wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data got %h want 00", bus.wr_data); end
      tests++;
      if ({bus.latch_cmd, bus.rd_strobe, bus.wr_strobe, bus.err} !== 4'b0000) begin
         fails++; $display("FAIL reset_pulses got %b want 0000", {bus.latch_cmd, bus.rd_strobe, bus.wr_strobe, bus.err});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_wr_single();
      int wr0 = wr_cnt;
      int lt0 = latch_cnt;
      send_byte(8'h20);
      tests++; if (bus.latch_cmd !== 1'b1) begin fails++; $display("FAIL wr1_latch got %b want 1", bus.latch_cmd); end
      send_byte(8'h10);
      tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL wr1_busy_addr got %b want 1", bus.busy); end
      tests++; if (bus.addr !== 8'h10) begin fails++; $display("FAIL wr1_addr_phase got %h want 10", bus.addr); end
      send_byte(8'hAB);
      tests++; if (bus.wr_strobe !== 1'b1) begin fails++; $display("FAIL wr1_strobe got %b want 1", bus.wr_strobe); end
      tests++; if (bus.addr !== 8'h10) begin fails++; $display("FAIL wr1_addr got %h want 10", bus.addr); end
      tests++; if (bus.wr_data !== 8'hAB) begin fails++; $display("FAIL wr1_data got %h want ab", bus.wr_data); end
      @(negedge clk);
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL wr1_busy_fall got %b want 0", bus.busy); end
      tests++; if (wr_cnt - wr0 != 1) begin fails++; $display("FAIL wr1_strobe_count got %0d want 1", wr_cnt - wr0); end
      tests++; if (latch_cnt - lt0 != 1) begin fails++; $display("FAIL wr1_latch_count got %0d want 1", latch_cnt - lt0); end
   endtask

   task automatic test_rd_burst();
      int rd0 = rd_cnt;
      send_byte(8'h13);
      send_byte(8'h40);
      tests++; if (bus.rd_strobe !== 1'b1) begin fails++; $display("FAIL rd_entry_strobe got %b want 1", bus.rd_strobe); end
      for (int i = 0; i < 4; i++) send_byte(8'h00);
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rd_idle got busy=%b want 0", bus.busy); end
      tests++; if (rd_cnt - rd0 != 4) begin fails++; $display("FAIL rd_count got %0d want 4", rd_cnt - rd0); end
      for (int i = 0; i < 4; i++) begin
         logic [7:0] exp_a;
         exp_a = 8'h40 + 8'(i);
         tests++;
         if (rd_addr_log[(rd0 + i) % 16] !== exp_a) begin
            fails++; $display("FAIL rd_addr_%0d got %h want %h", i, rd_addr_log[(rd0 + i) % 16], exp_a);
         end
      end
   endtask

   task automatic test_addr_wrap();
      int wr0 = wr_cnt;
      send_byte(8'h21);
      send_byte(8'hFF);
      send_byte(8'h11);
      send_byte(8'h22);
      @(negedge clk);
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL wrap_idle got busy=%b want 0", bus.busy); end
      tests++; if (wr_cnt - wr0 != 2) begin fails++; $display("FAIL wrap_count got %0d want 2", wr_cnt - wr0); end
      tests++;
      if ({wr_addr_log[wr0 % 16], wr_data_log[wr0 % 16]} !== 16'hFF11) begin
         fails++; $display("FAIL wrap_first got %h=%h want ff=11", wr_addr_log[wr0 % 16], wr_data_log[wr0 % 16]);
      end
      tests++;
      if ({wr_addr_log[(wr0 + 1) % 16], wr_data_log[(wr0 + 1) % 16]} !== 16'h0022) begin
         fails++; $display("FAIL wrap_second got %h=%h want 00=22", wr_addr_log[(wr0 + 1) % 16], wr_data_log[(wr0 + 1) % 16]);
      end
   endtask

   task automatic test_bad_opcode();
      int st0 = wr_cnt + rd_cnt;
      int er0 = err_cnt;
      send_byte(8'h70);
      tests++; if (bus.latch_cmd !== 1'b1) begin fails++; $display("FAIL badop_latch got %b want 1", bus.latch_cmd); end
      @(negedge clk);
      tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL badop_err got %b want 1", bus.err); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL badop_idle got busy=%b want 0", bus.busy); end
      @(negedge clk);
      tests++; if (err_cnt - er0 != 1) begin fails++; $display("FAIL badop_err_pulses got %0d want 1", err_cnt - er0); end
      tests++; if (wr_cnt + rd_cnt != st0) begin fails++; $display("FAIL badop_strobes got %0d want 0", wr_cnt + rd_cnt - st0); end
   endtask

   task automatic test_timeout();
      int wr0 = wr_cnt;
      send_byte(8'h20);
      send_byte(8'h05);
      repeat (T - 1) @(negedge clk);
      tests++; if ({bus.busy, bus.err} !== 2'b10) begin fails++; $display("FAIL tmo_early busy,err got %b want 10", {bus.busy, bus.err}); end
      @(negedge clk);
      tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL tmo_err got %b want 1", bus.err); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL tmo_busy got %b want 0", bus.busy); end
      tests++; if (wr_cnt != wr0) begin fails++; $display("FAIL tmo_no_write got %0d want 0", wr_cnt - wr0); end
   endtask

   task automatic test_abort_and_reset();
      int rd0 = rd_cnt;
      int er0;
      send_byte(8'h13);
      send_byte(8'h40);
      er0 = err_cnt;
      @(negedge clk);
      bus.byte_done = 1'b1;
      bus.abort     = 1'b1;
      @(negedge clk);
      bus.byte_done = 1'b0;
      bus.abort     = 1'b0;
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", bus.busy); end
      tests++; if (bus.rd_strobe !== 1'b0) begin fails++; $display("FAIL abort_strobe got %b want 0", bus.rd_strobe); end
      tests++; if (rd_cnt - rd0 != 1) begin fails++; $display("FAIL abort_rd_count got %0d want 1", rd_cnt - rd0); end
      tests++; if (err_cnt != er0) begin fails++; $display("FAIL abort_err got %0d pulses want 0", err_cnt - er0); end
      tests++; if (bus.addr !== 8'h40) begin fails++; $display("FAIL abort_addr got %h want 40", bus.addr); end
      // reset in the middle of a write burst
      send_byte(8'h21);
      send_byte(8'h33);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if ({bus.busy, bus.addr, bus.wr_data, bus.wr_strobe, bus.err} !== 19'h0) begin
         fails++; $display("FAIL midrst_outputs got busy=%b addr=%h data=%h wr=%b err=%b want all 0",
                           bus.busy, bus.addr, bus.wr_data, bus.wr_strobe, bus.err);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      send_byte(8'h20);
      send_byte(8'h7E);
      send_byte(8'h5A);
      tests++;
      if ({bus.wr_strobe, bus.addr, bus.wr_data} !== 17'h17E5A) begin
         fails++; $display("FAIL b2b_write got wr=%b %h=%h want 1 7e=5a", bus.wr_strobe, bus.addr, bus.wr_data);
      end
      send_byte(8'h10);
      send_byte(8'h80);
      tests++;
      if ({bus.rd_strobe, bus.addr} !== 9'h180) begin
         fails++; $display("FAIL b2b_read got rd=%b addr=%h want 1 80", bus.rd_strobe, bus.addr);
      end
      send_byte(8'h00);
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_idle got busy=%b want 0", bus.busy); end
   endtask

   initial begin
      rst           = 1'b1;
      bus.byte_done = 1'b0;
      bus.rx_byte   = 8'h00;
      bus.abort     = 1'b0;
      test_reset();
      test_wr_single();
      test_rd_burst();
      test_addr_wrap();
      test_bad_opcode();
      test_timeout();
      test_abort_and_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
